// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared types and constants for the PWM stage
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } pwm_state_t;

  localparam int PERIOD_CNT_BITS = 16;

endpackage

// File: rtl/pwm_duty_buffer.sv
// rtl/pwm_duty_buffer.sv - double-buffered duty value, swapped on period boundaries
module pwm_duty_buffer #(
  parameter int COUNTER_BITS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    end_i,
  input  logic                    duty_valid_i,
  input  logic [COUNTER_BITS-1:0] duty_i,
  output logic                    duty_ready_o,
  output logic [COUNTER_BITS-1:0] duty_active_o
);

  logic [COUNTER_BITS-1:0] duty_pending;
  logic                    pending_valid;
  logic                    transfer;

  // The boundary frees the pending slot in the same cycle, so a new value can
  // be taken while the old one moves to active.
  assign duty_ready_o = !pending_valid || end_i;
  assign transfer     = duty_valid_i && duty_ready_o;

  // Pending slot fill and boundary swap; a transfer never lands in active directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_active_o <= '0;
      duty_pending  <= '0;
      pending_valid <= 1'b0;
    end else begin
      if (end_i && pending_valid) begin
        duty_active_o <= duty_pending;
      end
      if (transfer) begin
        duty_pending  <= duty_i;
        pending_valid <= 1'b1;
      end else if (end_i) begin
        pending_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pwm_from_counter.sv
// rtl/pwm_from_counter.sv - registered PWM with run control; optional PWM_PERIOD_CNT_EN period counter
module pwm_from_counter
  import pwm_pkg::*;
#(
  parameter int COUNTER_BITS = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [COUNTER_BITS-1:0]    cnt_i,
  input  logic                       end_i,
  input  logic                       en_i,
  input  logic                       duty_valid_i,
  input  logic [COUNTER_BITS-1:0]    duty_i,
  output logic                       duty_ready_o,
  output logic                       pwm_o,
`ifdef PWM_PERIOD_CNT_EN
  output logic [PERIOD_CNT_BITS-1:0] period_cnt_o,
`endif
  output logic                       running_o
);

  pwm_state_t              state, state_next;
  logic [COUNTER_BITS-1:0] duty_active;

  pwm_duty_buffer #(.COUNTER_BITS(COUNTER_BITS)) u_duty_buffer (
    .clk          (clk),
    .rst          (rst),
    .end_i        (end_i),
    .duty_valid_i (duty_valid_i),
    .duty_i       (duty_i),
    .duty_ready_o (duty_ready_o),
    .duty_active_o(duty_active)
  );

  assign running_o = (state == RUN) || (state == DRAIN);

  // Run-control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: starts wait for a boundary, stops let the current period finish.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (en_i) state_next = ARM;
      ARM:     if (!en_i) state_next = IDLE;
               else if (end_i) state_next = RUN;
      RUN:     if (!en_i) state_next = end_i ? IDLE : DRAIN;
      DRAIN:   if (end_i) state_next = IDLE;
               else if (en_i) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  // Registered compare; duty 0 never fires and duty above terminal always fires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_o <= 1'b0;
    end else begin
      pwm_o <= running_o && (cnt_i < duty_active);
    end
  end

`ifdef PWM_PERIOD_CNT_EN
  // Count periods completed while the output was live; wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_cnt_o <= '0;
    end else if (end_i && running_o) begin
      period_cnt_o <= period_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pwm_from_counter.sv
// tb/tb_pwm_from_counter.sv - randomized scoreboard bench for pwm_from_counter
module tb_pwm_from_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cnt_i;
  logic       end_i;
  logic       en_i;
  logic       duty_valid_i;
  logic [7:0] duty_i;
  logic       duty_ready_o;
  logic       pwm_o;
  logic       running_o;
`ifdef PWM_PERIOD_CNT_EN
  logic [15:0] period_cnt_o;
`endif

  pwm_from_counter #(.COUNTER_BITS(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .cnt_i       (cnt_i),
    .end_i       (end_i),
    .en_i        (en_i),
    .duty_valid_i(duty_valid_i),
    .duty_i      (duty_i),
    .duty_ready_o(duty_ready_o),
    .pwm_o       (pwm_o),
`ifdef PWM_PERIOD_CNT_EN
    .period_cnt_o(period_cnt_o),
`endif
    .running_o   (running_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        pwm;
    logic        run;
    logic        rdy;
    logic [15:0] pc;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model: run mode, active/pending duty, produced output level.
  localparam int M_IDLE = 0, M_ARM = 1, M_RUN = 2, M_DRAIN = 3;
  int mode;
  bit m_pwm;
  int m_active, m_pend;
  bit m_pv;
  int m_pc;

  // Upstream counter model.
  int cnt = 0, term = 5, next_term = 5;

  function automatic void model_reset();
    mode = M_IDLE; m_pwm = 0; m_active = 0; m_pend = 0; m_pv = 0; m_pc = 0;
  endfunction

  function automatic bit live();
    return (mode == M_RUN) || (mode == M_DRAIN);
  endfunction

  // Apply one clock edge of the rules to the model, using the inputs just held.
  function automatic void model_edge(int c, bit e, bit en, bit dv, int d);
    bit xfer;
    xfer = dv && (!m_pv || e);
    m_pwm = live() && (c < m_active);
    if (e && live()) m_pc = (m_pc + 1) % 65536;
    if (e && m_pv) m_active = m_pend;
    if (xfer) begin m_pend = d; m_pv = 1; end
    else if (e) m_pv = 0;
    case (mode)
      M_IDLE:  if (en) mode = M_ARM;
      M_ARM:   if (!en) mode = M_IDLE; else if (e) mode = M_RUN;
      M_RUN:   if (!en) mode = e ? M_IDLE : M_DRAIN;
      default: if (e) mode = M_IDLE; else if (en) mode = M_RUN;
    endcase
  endfunction

  // One cycle: advance models on the previous inputs, drive new ones, push expectation.
  task automatic step(input bit r, input bit en, input bit dv, input int d);
    @(posedge clk);
    #2;
    if (!rst) model_edge(cnt_i, end_i, en_i, duty_valid_i, duty_i);
    if (cnt == term) begin cnt = 0; term = next_term; end
    else cnt = cnt + 1;
    rst = r;
    if (r) model_reset();
    cnt_i = cnt[7:0];
    end_i = (cnt == term);
    en_i = en;
    duty_valid_i = dv;
    duty_i = d[7:0];
    q.push_back('{pwm: m_pwm, run: live(), rdy: (!m_pv || end_i), pc: m_pc[15:0]});
  endtask

  // Monitor: compare DUT outputs against the oldest expectation, mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      vectors++;
      if (pwm_o !== e.pwm) begin
        miscompares++;
        $display("FAIL pwm_o t=%0t got %b expected %b", $time, pwm_o, e.pwm);
      end
      if (running_o !== e.run) begin
        miscompares++;
        $display("FAIL running_o t=%0t got %b expected %b", $time, running_o, e.run);
      end
      if (duty_ready_o !== e.rdy) begin
        miscompares++;
        $display("FAIL duty_ready_o t=%0t got %b expected %b", $time, duty_ready_o, e.rdy);
      end
`ifdef PWM_PERIOD_CNT_EN
      if (period_cnt_o !== e.pc) begin
        miscompares++;
        $display("FAIL period_cnt_o t=%0t got %0d expected %0d", $time, period_cnt_o, e.pc);
      end
`endif
    end
  end

  function automatic int pick_duty(int t);
    case ($urandom_range(0, 4))
      0:       return 0;
      1:       return 200;
      2:       return 255;
      3:       return t + 1;
      default: return $urandom_range(0, 15);
    endcase
  endfunction

  initial begin
    bit en;
    int d;
    rst = 1'b1; cnt_i = 0; end_i = 0; en_i = 0; duty_valid_i = 0; duty_i = 0;
    model_reset();
    repeat (3) step(1, 0, 0, 0);

    // Steady PWM: terminal 5, duty 3.
    step(0, 1, 1, 3);
    repeat (40) step(0, 1, 0, 0);

    // Reset mid-period, then resume.
    repeat (2) step(1, 1, 0, 0);
    step(0, 1, 1, 2);
    repeat (20) step(0, 1, 0, 0);

    // Boundary swap: offer 4 mid-period, then keep offering to see backpressure.
    while (cnt != 2) step(0, 1, 0, 0);
    step(0, 1, 1, 4);
    repeat (4) step(0, 1, 1, 6);
    repeat (14) step(0, 1, 0, 0);

    // Simultaneous transfer at boundary: pending 1, offer 5 exactly on end_i.
    step(0, 1, 1, 1);
    while (cnt != term - 1) step(0, 1, 0, 0);
    step(0, 1, 1, 5);
    repeat (20) step(0, 1, 0, 0);

    // Extremes.
    step(0, 1, 1, 0);
    repeat (20) step(0, 1, 0, 0);
    step(0, 1, 1, 200);
    repeat (20) step(0, 1, 0, 0);

    // Stop at cnt 2, drain, stay idle.
    while (cnt != 1) step(0, 1, 0, 0);
    repeat (20) step(0, 0, 0, 0);

    // Randomized phases with varying terminal, run requests and offers.
    for (int p = 0; p < 10; p++) begin
      next_term = $urandom_range(0, 12);
      en = 1;
      for (int i = 0; i < 60; i++) begin
        if ($urandom_range(0, 15) == 0) en = ~en;
        d = pick_duty(next_term);
        step((p == 6 && i == 30), en, ($urandom_range(0, 3) == 0) || (p == 3), d);
      end
    end

    en_i = 0;
    repeat (10) step(0, 0, 0, 0);
    for (int w = 0; w < 10 && q.size() > 0; w++) @(posedge clk);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain left %0d expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pwm_from_counter.md
# pwm_from_counter

Downstream consumer of the synchronous counter stage: takes the running count and the one-cycle terminal pulse and produces a registered PWM waveform. The duty value is double-buffered behind a valid/ready handshake and applied only on period boundaries, so the output never glitches mid-period. A small run-control state machine starts and stops the output cleanly on period boundaries.

## Interface
- COUNTER_BITS, 8, width of the count and duty values; matches the upstream counter width.
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cnt_i  in  COUNTER_BITS  running count from the upstream counter; 0..terminal, then wraps to 0.
- end_i  in  1  one-cycle pulse, high in the cycle where cnt_i equals terminal; the next cycle has cnt_i = 0.
- en_i  in  1  run request (level).
- duty_valid_i  in  1  new duty offered.
- duty_i  in  COUNTER_BITS  duty value (number of high cycles per period).
- duty_ready_o  out  1  pending slot can accept a duty value.
- pwm_o  out  1  PWM output (registered).
- running_o  out  1  high in the RUN and DRAIN states.
- period_cnt_o  out  16  completed RUN/DRAIN periods; wraps at 0xFFFF (present only with PWM_PERIOD_CNT_EN).

## Operation
- Registers: duty_active, duty_pending, pending_valid, state, pwm_o, period_cnt.
- Handshake: a transfer occurs when duty_valid_i && duty_ready_o. duty_ready_o = !pending_valid || end_i. An accepted value is written to duty_pending and pending_valid is set.
- Boundary swap: on end_i with pending_valid, duty_active <= duty_pending. pending_valid clears, unless a transfer occurs in the same cycle; then the new value goes to pending and stays valid for the next boundary. A transfer never bypasses directly to active.
- States:
  - IDLE: pwm_o = 0. Moves to ARM when en_i = 1.
  - ARM: pwm_o = 0. Moves to RUN on end_i, or back to IDLE if en_i drops first.
  - RUN: moves to DRAIN when en_i = 0. If end_i is in the same cycle, it moves straight to IDLE.
  - DRAIN: finishes the current period. Moves to IDLE on end_i. en_i reasserting in DRAIN returns to RUN.
- Compare: in RUN/DRAIN, next pwm_o = (cnt_i < duty_active).
  - duty 0: output is constant low.
  - duty > terminal: output is constant high.
  - Unsigned compare at COUNTER_BITS, no extension.
- Period counter: increments on end_i while in RUN or DRAIN.
- Reset (any time, including mid-period) forces every register to 0. State = IDLE, pending empty, duty_ready_o = 1.

## Timing
- Reset values: pwm_o = 0, running_o = 0, duty_ready_o = 1, period_cnt_o = 0.
- pwm_o latency: 1 cycle. pwm_o at t+1 reflects cnt_i and duty_active at t.
- A duty accepted at cycle t becomes active after the first end_i at or after t+1. Its first effect on pwm_o is 2 cycles after that end_i.
- ARM→RUN transitions on the end_i edge. The first compared count is 0, and the first high pwm_o appears one cycle later.
- DRAIN→IDLE: the pwm_o sample taken at the end_i cycle is still driven. pwm_o is 0 from end_i+2 onward.
- running_o is decoded combinationally from the state register.

## Configuration
- PWM_PERIOD_CNT_EN:
  - Defined: period_cnt register and the period_cnt_o port exist and behave as above.
  - Undefined: port and logic are removed entirely; all other behaviour is identical.

## Structure
- The shared package pwm_pkg holds:
  - the state enum pwm_state_t (IDLE, ARM, RUN, DRAIN);
  - the localparam PERIOD_CNT_BITS = 16.
- One sub-module, pwm_duty_buffer, contains the pending/active registers and the ready logic. The top level holds the FSM, the compare and the period counter.

## Test plan
- Reset mid-run: upstream terminal 5, duty 3, RUN. Assert rst for 2 cycles mid-period → pwm_o = 0, running_o = 0, duty_ready_o = 1 immediately, and period_cnt_o = 0.
- Steady PWM: terminal 5, duty 3, en_i = 1 → after ARM, each 6-cycle period shows pwm_o high 3 cycles, low 3 cycles, lagging cnt_i by 1 cycle.
- Boundary swap: duty 2 active; offer 4 mid-period → accepted; current period stays 2-high; next period is 4-high. A second offer before the boundary holds with duty_ready_o = 0.
- Simultaneous transfer and end_i with pending = 1, offered value 5 → active becomes 1; 5 stays pending until the following end_i.
- Extremes: duty 0 → pwm_o constantly 0. Duty 200 with terminal 5 → pwm_o constantly 1 during RUN.
- Stop/drain: drop en_i at cnt_i = 2 → period completes; state is IDLE after end_i; period_cnt_o has counted that period (with PWM_PERIOD_CNT_EN); pwm_o stays 0 thereafter.
